// File: rtl/phase_det_seq.sv
// Measurement sequencer for phase_det: enable, discard settling samples, accumulate, present sum.
// Latency: result valid the cycle after the final sample strobe, or after the watchdog expires.
// Backpressure: the result is held in OUT until i_ready; strobes and starts are ignored meanwhile.
module phase_det_seq #(
    parameter int TIC_BITS  = 9,
    parameter int NAVG_BITS = 8,
    parameter int DISCARD   = 2,
    parameter int TMO_BITS  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic                          i_mode_slow,
    input  logic [NAVG_BITS-1:0]          i_navg,
    output logic                          o_pd_en,
    output logic                          o_pd_eclk2_slow,
    input  logic [TIC_BITS-1:0]           i_pd_count,
    input  logic                          i_pd_count_rdy,
    output logic [TIC_BITS+NAVG_BITS-1:0] o_sum,
    output logic [NAVG_BITS-1:0]          o_nsamp,
    output logic                          o_timeout,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_busy
);

    localparam int SUM_BITS = TIC_BITS + NAVG_BITS;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_ACCUM  = 2'd2;
    localparam logic [1:0] ST_OUT    = 2'd3;

    // Expiry fires on the strobe-less cycle that would bring the watchdog to all-ones.
    localparam logic [TMO_BITS-1:0] WDOG_LAST = {TMO_BITS{1'b1}} - 1'b1;
    localparam logic [3:0]          DISC_LAST = 4'(DISCARD - 1);

    logic [1:0]           state;
    logic [3:0]           disc_cnt;
    logic [NAVG_BITS-1:0] navg_lat;
    logic [TMO_BITS-1:0]  wdog;
    logic                 expire;

    assign expire = (wdog == WDOG_LAST) && !i_pd_count_rdy;
    assign o_busy = (state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            disc_cnt        <= '0;
            navg_lat        <= '0;
            wdog            <= '0;
            o_pd_en         <= 1'b0;
            o_pd_eclk2_slow <= 1'b0;
            o_sum           <= '0;
            o_nsamp         <= '0;
            o_timeout       <= 1'b0;
            o_valid         <= 1'b0;
        end else if (state != ST_IDLE && i_abort) begin
            state           <= ST_IDLE;
            o_pd_en         <= 1'b0;
            o_pd_eclk2_slow <= 1'b0;
            o_valid         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        state           <= (DISCARD == 0) ? ST_ACCUM : ST_SETTLE;
                        o_pd_en         <= 1'b1;
                        o_pd_eclk2_slow <= i_mode_slow;
                        navg_lat        <= (i_navg == '0) ? NAVG_BITS'(1) : i_navg;
                        o_sum           <= '0;
                        o_nsamp         <= '0;
                        o_timeout       <= 1'b0;
                        disc_cnt        <= '0;
                        wdog            <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (i_pd_count_rdy) begin
                        wdog     <= '0;
                        disc_cnt <= disc_cnt + 4'd1;
                        if (disc_cnt == DISC_LAST) begin
                            state <= ST_ACCUM;
                        end
                    end else if (expire) begin
                        state     <= ST_OUT;
                        o_timeout <= 1'b1;
                        o_valid   <= 1'b1;
                        o_pd_en   <= 1'b0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (i_pd_count_rdy) begin
                        wdog    <= '0;
                        o_sum   <= o_sum + SUM_BITS'(i_pd_count);
                        o_nsamp <= o_nsamp + 1'b1;
                        if (o_nsamp == navg_lat - 1'b1) begin
                            state   <= ST_OUT;
                            o_valid <= 1'b1;
                            o_pd_en <= 1'b0;
                        end
                    end else if (expire) begin
                        state     <= ST_OUT;
                        o_timeout <= 1'b1;
                        o_valid   <= 1'b1;
                        o_pd_en   <= 1'b0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        state           <= ST_IDLE;
                        o_valid         <= 1'b0;
                        o_pd_eclk2_slow <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_det_seq.sv
// Bench for phase_det_seq: per-run transaction model (strobe gaps and values) predicts result and timing.
module tb_phase_det_seq;

    localparam int TIC_BITS  = 9;
    localparam int NAVG_BITS = 8;
    localparam int DISCARD   = 2;
    localparam int TMO_BITS  = 6;
    localparam int TMO_CYC   = (1 << TMO_BITS) - 1;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          start = 1'b0;
    logic                          abort = 1'b0;
    logic                          mode_slow = 1'b0;
    logic [NAVG_BITS-1:0]          navg = '0;
    logic                          pd_en;
    logic                          pd_slow;
    logic [TIC_BITS-1:0]           pd_count = '0;
    logic                          pd_rdy = 1'b0;
    logic [TIC_BITS+NAVG_BITS-1:0] sum;
    logic [NAVG_BITS-1:0]          nsamp;
    logic                          timeout;
    logic                          valid;
    logic                          ready = 1'b0;
    logic                          busy;

    phase_det_seq #(
        .TIC_BITS(TIC_BITS), .NAVG_BITS(NAVG_BITS), .DISCARD(DISCARD), .TMO_BITS(TMO_BITS)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_mode_slow(mode_slow), .i_navg(navg), .o_pd_en(pd_en), .o_pd_eclk2_slow(pd_slow),
        .i_pd_count(pd_count), .i_pd_count_rdy(pd_rdy), .o_sum(sum), .o_nsamp(nsamp),
        .o_timeout(timeout), .o_valid(valid), .i_ready(ready), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int gap_q[$];
    int val_q[$];
    int plan_rdy[$];
    int plan_cnt[$];

    // Reference: walk the planned strobes; gaps of TMO_CYC idle cycles end the run early.
    task automatic build(input int n_req, output int vat, output int es, output int en, output bit eto);
        int  eff;
        int  t;
        bit  done;
        eff = (n_req == 0) ? 1 : n_req;
        t = 0; done = 0; es = 0; en = 0; eto = 0; vat = 0;
        plan_rdy.delete();
        plan_cnt.delete();
        foreach (gap_q[i]) begin
            if (done) break;
            if (gap_q[i] >= TMO_CYC) begin
                vat = t + TMO_CYC; eto = 1; done = 1;
            end else begin
                repeat (gap_q[i]) begin
                    plan_rdy.push_back(0);
                    plan_cnt.push_back($urandom_range(0, 511));
                end
                plan_rdy.push_back(1);
                plan_cnt.push_back(val_q[i]);
                t += gap_q[i] + 1;
                if (i >= DISCARD) begin
                    es += val_q[i];
                    en++;
                    if (en == eff) begin
                        vat = t; done = 1;
                    end
                end
            end
        end
        if (!done) begin
            vat = t + TMO_CYC; eto = 1;
        end
        while (plan_rdy.size() < vat) begin
            plan_rdy.push_back(0);
            plan_cnt.push_back($urandom_range(0, 511));
        end
    endtask

    // abort_at: -1 none, -2 abort while result is held, 0 random cycle in run, >0 that cycle.
    task automatic do_run(input int n_req, input bit mode, input int abort_at, input int hold);
        int vat, es, en, ab;
        bit eto;
        build(n_req, vat, es, en, eto);
        ab = (abort_at == 0) ? $urandom_range(1, vat) : abort_at;
        mode_slow = mode;
        navg = NAVG_BITS'(n_req);
        start = 1'b1;
        tick();
        start = 1'b0;
        mode_slow = 1'($urandom_range(0, 1));
        navg = NAVG_BITS'($urandom_range(0, 255));
        check("start_busy", 32'(busy), 1);
        check("start_pd_en", 32'(pd_en), 1);
        check("start_slow", 32'(pd_slow), 32'(mode));
        for (int c = 1; c <= vat; c++) begin
            pd_rdy = 1'(plan_rdy[c-1]);
            pd_count = TIC_BITS'(plan_cnt[c-1]);
            start = 1'($urandom_range(0, 1));
            if (c == ab) abort = 1'b1;
            tick();
            pd_rdy = 1'b0; start = 1'b0; abort = 1'b0;
            if (c == ab) begin
                check("abort_busy", 32'(busy), 0);
                check("abort_pd_en", 32'(pd_en), 0);
                check("abort_valid", 32'(valid), 0);
                tick();
                check("abort_novalid", 32'(valid), 0);
                return;
            end
            check("run_valid", 32'(valid), 32'(c == vat));
            check("run_pd_en", 32'(pd_en), 32'(c < vat));
            check("run_slow", 32'(pd_slow), 32'(mode));
        end
        check("res_sum", 32'(sum), 32'(es));
        check("res_nsamp", 32'(nsamp), 32'(en));
        check("res_timeout", 32'(timeout), 32'(eto));
        repeat (hold) begin
            start = 1'($urandom_range(0, 1));
            pd_rdy = 1'($urandom_range(0, 1));
            pd_count = TIC_BITS'($urandom_range(0, 511));
            tick();
            check("hold_valid", 32'(valid), 1);
            check("hold_sum", 32'(sum), 32'(es));
            check("hold_nsamp", 32'(nsamp), 32'(en));
            check("hold_busy", 32'(busy), 1);
        end
        start = 1'b0; pd_rdy = 1'b0;
        if (abort_at == -2) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("out_abort_valid", 32'(valid), 0);
            check("out_abort_busy", 32'(busy), 0);
            return;
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("done_valid", 32'(valid), 0);
        check("done_busy", 32'(busy), 0);
        check("done_slow", 32'(pd_slow), 0);
        check("done_pd_en", 32'(pd_en), 0);
    endtask

    task automatic set_run(input int g0, input int g1, input int g2, input int ng, input int n);
        gap_q.delete();
        val_q.delete();
        for (int i = 0; i < n; i++) begin
            gap_q.push_back(i == 0 ? g0 : i == 1 ? g1 : i == 2 ? g2 : ng);
            val_q.push_back($urandom_range(0, 511));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_pd_en", 32'(pd_en), 0);
        check("rst_slow", 32'(pd_slow), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_nsamp", 32'(nsamp), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Start together with abort in IDLE, and strobes in IDLE, do nothing.
        start = 1'b1; abort = 1'b1; pd_rdy = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0; pd_rdy = 1'b0;
        check("idle_abort_start", 32'(busy), 0);
        check("idle_abort_pd_en", 32'(pd_en), 0);

        gap_q = '{0, 0, 0, 0, 0, 0};
        val_q = '{500, 501, 10, 20, 30, 40};
        do_run(4, 1'b0, -1, 0);

        gap_q = '{0, 0, 0};
        val_q = '{17, 18, 300};
        do_run(0, 1'b1, -1, 10);

        gap_q = '{0, 0, 0, 0};
        val_q = '{1, 2, 7, 9};
        do_run(5, 1'b0, -1, 1);

        gap_q = '{0, 0, 0, 62};
        val_q = '{1, 2, 3, 44};
        do_run(2, 1'b0, -1, 0);

        gap_q = '{1, 0, 63};
        val_q = '{5, 6, 7};
        do_run(3, 1'b1, -1, 0);

        gap_q = '{0, 0, 0, 0, 0, 0};
        val_q = '{9, 9, 100, 200, 300, 400};
        do_run(4, 1'b0, 5, 0);
        val_q = '{9, 9, 1, 2, 3, 4};
        do_run(4, 1'b0, -1, 0);

        gap_q = '{0, 0, 0};
        val_q = '{1, 1, 77};
        do_run(1, 1'b1, -2, 3);

        for (int r = 0; r < 25; r++) begin
            int n_req, eff, ns, sel;
            n_req = $urandom_range(0, 6);
            eff = (n_req == 0) ? 1 : n_req;
            ns = DISCARD + eff - (($urandom_range(0, 7) == 0) ? 1 : 0);
            gap_q.delete();
            val_q.delete();
            for (int i = 0; i < ns; i++) begin
                int g;
                g = $urandom_range(0, 24);
                gap_q.push_back(g == 0 ? 62 : g == 1 ? 63 : g == 2 ? 70 : g % 3);
                val_q.push_back($urandom_range(0, 511));
            end
            sel = $urandom_range(0, 7);
            do_run(n_req, 1'($urandom_range(0, 1)), sel == 0 ? 0 : sel == 1 ? -2 : -1,
                   $urandom_range(0, 4));
        end

        // Asynchronous reset in the middle of accumulation.
        set_run(0, 0, 0, 0, 6);
        mode_slow = 1'b1; navg = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pd_rdy = 1'b1;
            pd_count = TIC_BITS'(val_q[i]);
            tick();
        end
        pd_rdy = 1'b0;
        check("pre_rst_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pd_en", 32'(pd_en), 0);
        check("arst_slow", 32'(pd_slow), 0);
        check("arst_sum", 32'(sum), 0);
        check("arst_nsamp", 32'(nsamp), 0);
        check("arst_valid", 32'(valid), 0);
        check("arst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            pd_rdy = 1'b1;
            tick();
            check("post_rst_idle", 32'(busy), 0);
        end
        pd_rdy = 1'b0;

        gap_q = '{0, 2, 1};
        val_q = '{4, 4, 123};
        do_run(1, 1'b0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/phase_det_seq.md
Name: phase_det_seq

Overview:
- Measurement sequencer for the phase_det block.
- On a start command it enables phase_det and selects the eclk2 fast/slow mode.
- It discards the first samples after enable, accumulates a programmable number of o_count samples, and presents the sum with a valid/ready handshake.
- A watchdog ends the run if samples stop arriving, e.g. a dead external clock.

Parameters:
TIC_BITS, 9, width of phase_det count samples
NAVG_BITS, 8, width of the sample-count request; up to 2^NAVG_BITS-1 samples
DISCARD, 2, samples dropped after each enable (settling), 0..15
TMO_BITS, 16, watchdog counter width; timeout after 2^TMO_BITS-1 cycles without a sample

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start request pulse/level, sampled in IDLE only
i_abort  in  1  abandon the current run
i_mode_slow  in  1  requested eclk2 slow mode, latched at start
i_navg  in  NAVG_BITS  samples to accumulate, latched at start; 0 is treated as 1
o_pd_en  out  1  drives phase_det i_en
o_pd_eclk2_slow  out  1  drives phase_det i_eclk2_slow
i_pd_count  in  TIC_BITS  phase_det o_count
i_pd_count_rdy  in  1  phase_det o_count_rdy, single-cycle strobe
o_sum  out  TIC_BITS+NAVG_BITS  accumulated sum
o_nsamp  out  NAVG_BITS  samples actually summed
o_timeout  out  1  result ended by watchdog
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result
o_busy  out  1  high in any state except IDLE

Behaviour:
- Async reset state: IDLE. All outputs 0, accumulator 0, counters 0, latched mode/navg 0.
- States and transitions:
  - IDLE -> SETTLE (or ACCUM if DISCARD=0) on the clock edge where i_start=1.
    - At that edge, latch i_mode_slow and max(i_navg,1); clear sum, nsamp, discard counter and watchdog.
    - o_pd_en and o_pd_eclk2_slow are registered; they go high on that same edge (visible the cycle after i_start).
  - SETTLE: each i_pd_count_rdy increments the discard counter; sample ignored. After the DISCARD-th strobe -> ACCUM.
  - ACCUM: each i_pd_count_rdy adds zero-extended i_pd_count to the sum and increments nsamp. The strobe that makes nsamp equal the latched navg -> OUT.
  - OUT:
    - o_pd_en=0 (registered; phase_det is disabled from the first OUT cycle).
    - o_valid=1; o_sum, o_nsamp and o_timeout are held stable until the cycle with o_valid&i_ready, then -> IDLE.
    - o_valid drops the following cycle; o_pd_eclk2_slow is cleared in IDLE.
- Watchdog:
  - Runs in SETTLE and ACCUM; reloads to 0 on every i_pd_count_rdy and on entry.
  - On reaching all-ones -> OUT with o_timeout=1; o_sum/o_nsamp hold the partial result (nsamp may be 0).
- Sum width TIC_BITS+NAVG_BITS cannot overflow; no saturation logic.
- Boundary and priority rules:
  - i_abort in SETTLE/ACCUM/OUT -> IDLE next edge. No o_valid is produced; o_valid clears immediately if already in OUT. i_abort in IDLE has no effect.
  - i_abort and i_pd_count_rdy in the same cycle: abort wins; the sample is dropped.
  - i_abort and i_start in the same cycle in IDLE: start is ignored.
  - i_pd_count_rdy in the same cycle as watchdog expiry: the sample is counted, the watchdog reloads, no timeout.
  - i_start while busy is ignored. Changes to i_mode_slow/i_navg while busy have no effect.
  - i_pd_count_rdy in IDLE or OUT is ignored.
  - Async reset mid-run returns to IDLE immediately with o_pd_en=0 and o_valid=0. Any result not yet accepted is lost.
- Throughput: the next run can start the cycle after handshake completion (IDLE with i_start=1).

Test Plan:
- DISCARD=2, navg=4, samples 500,501 then 10,20,30,40 -> 500/501 discarded; o_valid with o_sum=100, o_nsamp=4, o_timeout=0; o_pd_en high from the cycle after start until OUT entry.
- navg=0, mode_slow=1 -> o_pd_eclk2_slow=1 throughout the run; exactly one sample 300 summed; o_sum=300, o_nsamp=1.
- Backpressure: hold i_ready=0 for 10 cycles in OUT and pulse i_start and i_pd_count_rdy meanwhile -> o_sum/o_nsamp stable, state unchanged; IDLE one cycle after i_ready=1.
- TMO_BITS=6, navg=5, feed 2 samples (7,9) then stop -> 63 cycles after the last strobe: o_valid with o_timeout=1, o_sum=16, o_nsamp=2.
- Abort after 2 of 4 accumulated samples, with a same-cycle strobe -> o_busy=0 and o_pd_en=0 next cycle; no o_valid. A new start then yields a fresh sum starting from 0.
- Assert i_rst_n low asynchronously (between clock edges) during ACCUM -> all outputs 0 before the next clock edge; after release, idle until i_start.
